// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the sequential bubble sorter.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Worst-case number of compare-and-order steps (fully reversed input).
    function automatic int max_compares(input int dim);
        return dim * (dim - 1) / 2;
    endfunction

    // Width of the j/level index counters; never narrower than one bit.
    function automatic int idx_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    // Width of the swap counter; never narrower than one bit.
    function automatic int swap_width(input int dim);
        return (max_compares(dim) > 0) ? $clog2(max_compares(dim) + 1) : 1;
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Single compare-and-order unit, time-shared across all pair positions.
module sort_cmp_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             swapped
);

    // Strict unsigned compare so equal elements keep their order.
    always_comb begin
        swapped = (a > b);
        lo      = swapped ? b : a;
        hi      = swapped ? a : b;
    end

endmodule

// File: rtl/sort_sequencer.sv
// Sequential bubble sorter: one adjacent pair per cycle, early exit after
// a pass with no swaps, result held until the consumer takes it.
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DIM*WIDTH-1:0]         in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DIM*WIDTH-1:0]         out_data,
    output logic                         busy,
    output logic [swap_width(DIM)-1:0]   swap_cnt
);

    localparam int CW = idx_width(DIM);
    localparam int SW = swap_width(DIM);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] arr_q [DIM];
    logic [WIDTH-1:0] arr_d [DIM];
    logic [CW-1:0]    level_q, level_d;
    logic [CW-1:0]    j_q, j_d;
    logic             pass_swapped_q, pass_swapped_d;
    logic [SW-1:0]    swap_cnt_q, swap_cnt_d;

    logic [WIDTH-1:0] op_a, op_b, op_lo, op_hi;
    logic             op_swap;

    // Select the current pair a[j], a[j+1] for the shared compare unit.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < DIM; i++) begin
            if (CW'(i) == j_q)          op_a = arr_q[i];
            if (CW'(i) == j_q + CW'(1)) op_b = arr_q[i];
        end
    end

    sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
        .a       (op_a),
        .b       (op_b),
        .lo      (op_lo),
        .hi      (op_hi),
        .swapped (op_swap)
    );

    // Next-state, counter and array update logic.
    always_comb begin
        state_d        = state_q;
        arr_d          = arr_q;
        level_d        = level_q;
        j_d            = j_q;
        pass_swapped_d = pass_swapped_q;
        swap_cnt_d     = swap_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < DIM; i++) begin
                        arr_d[i] = in_data[WIDTH*i +: WIDTH];
                    end
                    level_d        = CW'(DIM - 1);
                    j_d            = '0;
                    pass_swapped_d = 1'b0;
                    swap_cnt_d     = '0;
                    state_d        = (DIM == 1) ? DONE : COMPARE;
                end
            end
            COMPARE: begin
                for (int i = 0; i < DIM; i++) begin
                    if (CW'(i) == j_q)          arr_d[i] = op_lo;
                    if (CW'(i) == j_q + CW'(1)) arr_d[i] = op_hi;
                end
                if (op_swap) begin
                    pass_swapped_d = 1'b1;
                    swap_cnt_d     = swap_cnt_q + SW'(1);
                end
                if (j_q < level_q - CW'(1)) begin
                    j_d = j_q + CW'(1);
                end else if ((level_q == CW'(1)) || !(pass_swapped_q || op_swap)) begin
                    state_d = DONE;
                end else begin
                    level_d        = level_q - CW'(1);
                    j_d            = '0;
                    pass_swapped_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, array and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            level_q        <= '0;
            j_q            <= '0;
            pass_swapped_q <= 1'b0;
            swap_cnt_q     <= '0;
            for (int i = 0; i < DIM; i++) arr_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            j_q            <= j_d;
            pass_swapped_q <= pass_swapped_d;
            swap_cnt_q     <= swap_cnt_d;
            for (int i = 0; i < DIM; i++) arr_q[i] <= arr_d[i];
        end
    end

    // Status outputs and packed view of the register array.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == COMPARE);
        swap_cnt  = swap_cnt_q;
        out_data  = '0;
        for (int i = 0; i < DIM; i++) out_data[WIDTH*i +: WIDTH] = arr_q[i];
    end

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer (DIM=4, WIDTH=8) against a sort/inversion model.
module tb_sort_sequencer;

    localparam int DIM   = 4;
    localparam int WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DIM*WIDTH-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [DIM*WIDTH-1:0] out_data;
    logic                 busy;
    logic [2:0]           swap_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sort_sequencer #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .swap_cnt  (swap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
        logic [31:0] p;
        p = {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
        return p;
    endfunction

    // Expected result: ascending order; swaps = strict inversions; passes =
    // one more than the largest count of bigger elements left of any element
    // (capped at DIM-1), pass k doing DIM-k compares.
    task automatic model(input logic [31:0] d, output logic [31:0] s,
                         output int inv, output int cmp);
        int e[DIM];
        int q[$];
        int g, p, passes;
        for (int i = 0; i < DIM; i++) begin
            e[i] = int'(d[WIDTH*i +: WIDTH]);
            q.push_back(e[i]);
        end
        q.sort();
        s = '0;
        for (int i = 0; i < DIM; i++) s[WIDTH*i +: WIDTH] = 8'(q[i]);
        inv = 0;
        p   = 0;
        for (int i = 0; i < DIM; i++) begin
            g = 0;
            for (int j = 0; j < i; j++) if (e[j] > e[i]) g++;
            inv += g;
            if (g > p) p = g;
        end
        passes = (p + 1 < DIM - 1) ? p + 1 : DIM - 1;
        cmp = 0;
        for (int k = 1; k <= passes; k++) cmp += DIM - k;
    endtask

    // Capture one array, wait for the result and check it; leaves DUT in DONE.
    task automatic start_and_wait(input logic [31:0] d, input string tag);
        logic [31:0] s;
        int inv, cmp, lat, busy_n;
        model(d, s, inv, cmp);
        @(negedge clk);
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!out_valid && lat < 50) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, ".latency"}, 32'(lat), 32'(cmp));
        check_eq({tag, ".busy_cycles"}, 32'(busy_n), 32'(cmp));
        check_eq({tag, ".out_data"}, out_data, s);
        check_eq({tag, ".swap_cnt"}, 32'(swap_cnt), 32'(inv));
        check_eq({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    endtask

    // Output handshake with an optional stall; checks hold-stability.
    task automatic finish_out(input int stall, input string tag);
        logic [31:0] hold_data;
        logic [2:0]  hold_cnt;
        hold_data = out_data;
        hold_cnt  = swap_cnt;
        for (int c = 0; c < stall; c++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check_eq({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
            check_eq({tag, ".hold_data"}, out_data, hold_data);
            check_eq({tag, ".hold_cnt"}, 32'(swap_cnt), 32'(hold_cnt));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".post_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".out_data"}, out_data, 32'd0);
        check_eq({tag, ".swap_cnt"}, 32'(swap_cnt), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        start_and_wait(pack4(40, 30, 20, 10), "reversed");
        finish_out(0, "reversed");
        start_and_wait(pack4(1, 2, 3, 4), "sorted");
        finish_out(0, "sorted");
        start_and_wait(pack4(5, 5, 0, 5), "dups");
        finish_out(0, "dups");
        start_and_wait(pack4(255, 0, 255, 0), "extremes");
        finish_out(0, "extremes");

        start_and_wait(pack4(3, 1, 2, 0), "bp");
        finish_out(5, "bp");
        start_and_wait(pack4(7, 6, 9, 8), "after_bp");
        finish_out(0, "after_bp");

        // Reset during COMPARE after two compares.
        @(negedge clk);
        in_data  = pack4(40, 30, 20, 10);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("midsort.busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        start_and_wait(pack4(9, 8, 7, 6), "post_reset");
        finish_out(0, "post_reset");

        for (int t = 0; t < 40; t++) begin
            d = $urandom;
            if (t % 2 == 1) begin
                for (int i = 0; i < DIM; i++) d[WIDTH*i +: WIDTH] = 8'($urandom_range(0, 3));
            end
            start_and_wait(d, "random");
            finish_out(int'($urandom_range(0, 2)), "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
